// File: rtl/ysyx_23060240_lsu_ctrl_if.sv
// Request, SRAM and write-back signals of the load/store control stage.
// The LSU takes the slave side; the execute/write-back/SRAM environment takes the master side.
interface ysyx_23060240_lsu_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [2:0]  in_funct3;
    logic        in_is_load;
    logic        in_is_store;

    logic [31:0] mem_raddr;
    logic [31:0] mem_waddr;
    logic [7:0]  mem_wmask;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;

    modport slave (
        input  in_valid, in_addr, in_wdata, in_funct3, in_is_load, in_is_store,
        output in_ready,
        output mem_raddr, mem_waddr, mem_wmask, mem_r_en, mem_w_en, mem_wdata,
        input  mem_rdata,
        output out_valid, out_data, out_err,
        input  out_ready
    );

    modport master (
        output in_valid, in_addr, in_wdata, in_funct3, in_is_load, in_is_store,
        input  in_ready,
        input  mem_raddr, mem_waddr, mem_wmask, mem_r_en, mem_w_en, mem_wdata,
        output mem_rdata,
        input  out_valid, out_data, out_err,
        output out_ready
    );
endinterface

// File: rtl/ysyx_23060240_lsu_ctrl.sv
// Load/store control stage in front of a single-cycle SRAM port: legality checks,
// lane masking/replication for stores, and load extraction with sign/zero extension.
module ysyx_23060240_lsu_ctrl (
    input  logic                        clk,
    input  logic                        rst,
    ysyx_23060240_lsu_ctrl_if.slave     bus
);

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        READ  = 5'b00010,
        RWAIT = 5'b00100,
        WRITE = 5'b01000,
        DONE  = 5'b10000
    } state_e;

    localparam int IDLE_B  = 0;
    localparam int READ_B  = 1;
    localparam int RWAIT_B = 2;
    localparam int WRITE_B = 3;
    localparam int DONE_B  = 4;

    state_e      state_q, state_d;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic [3:0]  wmask_q;
    logic [31:0] wdata_q;
    logic [31:0] out_data_q;
    logic        out_err_q;

    logic        accept;
    logic        misaligned;
    logic        bad_load;
    logic        bad_store;
    logic        req_err;
    logic [3:0]  st_mask;
    logic [31:0] st_data;
    logic [31:0] ld_shifted;
    logic [31:0] ld_ext;

    assign accept = bus.in_valid & bus.in_ready;

    // Request legality, evaluated on the raw inputs so the verdict is latched at accept.
    assign misaligned = (bus.in_funct3[1:0] == 2'b01 && bus.in_addr[0]) ||
                        (bus.in_funct3[1:0] == 2'b10 && bus.in_addr[1:0] != 2'b00);
    assign bad_load   = (bus.in_funct3 == 3'b011) || (bus.in_funct3 == 3'b110) ||
                        (bus.in_funct3 == 3'b111);
    assign bad_store  = bus.in_funct3[2] || (bus.in_funct3 == 3'b011);
    assign req_err    = (bus.in_is_load  & (bad_load  | misaligned)) |
                        (bus.in_is_store & (bad_store | misaligned));

    // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        st_mask = 4'b0000;
        st_data = bus.in_wdata;
        case (bus.in_funct3[1:0])
            2'b00: begin
                st_mask = 4'b0001 << bus.in_addr[1:0];
                st_data = {4{bus.in_wdata[7:0]}};
            end
            2'b01: begin
                st_mask = 4'b0011 << bus.in_addr[1:0];
                st_data = {2{bus.in_wdata[15:0]}};
            end
            2'b10: st_mask = 4'b1111;
            default: ;
        endcase
    end

    assign ld_shifted = bus.mem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        ld_ext = 32'h0;
        case (funct3_q)
            3'b000: ld_ext = {{24{ld_shifted[7]}},  ld_shifted[7:0]};
            3'b001: ld_ext = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            3'b010: ld_ext = ld_shifted;
            3'b100: ld_ext = {24'h0, ld_shifted[7:0]};
            3'b101: ld_ext = {16'h0, ld_shifted[15:0]};
            default: ld_ext = 32'h0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err)               state_d = DONE;
                    else if (bus.in_is_load)   state_d = READ;
                    else if (bus.in_is_store)  state_d = WRITE;
                    else                       state_d = DONE;
                end
            end
            READ:    state_d = RWAIT;
            RWAIT:   state_d = DONE;
            WRITE:   state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= 32'h0;
            funct3_q   <= 3'b000;
            wmask_q    <= 4'b0000;
            wdata_q    <= 32'h0;
            out_data_q <= 32'h0;
            out_err_q  <= 1'b0;
        end else if (accept) begin
            addr_q     <= bus.in_addr;
            funct3_q   <= bus.in_funct3;
            wmask_q    <= st_mask;
            wdata_q    <= st_data;
            out_data_q <= 32'h0;
            out_err_q  <= req_err;
        end else if (state_q[RWAIT_B]) begin
            out_data_q <= ld_ext;
        end
    end

    // Strobes come straight from one-hot state flops so they cannot glitch.
    assign bus.in_ready  = state_q[IDLE_B];
    assign bus.mem_r_en  = state_q[READ_B];
    assign bus.mem_w_en  = state_q[WRITE_B];
    assign bus.mem_raddr = {addr_q[31:2], 2'b00};
    assign bus.mem_waddr = {addr_q[31:2], 2'b00};
    assign bus.mem_wmask = {4'b0000, state_q[WRITE_B] ? wmask_q : 4'b0000};
    assign bus.mem_wdata = wdata_q;
    assign bus.out_valid = state_q[DONE_B];
    assign bus.out_data  = out_data_q;
    assign bus.out_err   = out_err_q;

endmodule

// File: doc/ysyx_23060240_lsu_ctrl.md
# ysyx_23060240_lsu_ctrl

Load/store control stage sitting directly upstream of the single-cycle-latency SRAM data port. It accepts one memory request at a time from the execute stage and checks alignment and funct3 legality. It drives the SRAM read/write strobes, byte-lane masks and replicated store data, then extracts and sign- or zero-extends load data. Results are handed to write-back over a valid/ready handshake.

## Interface
- none; datapath fixed at 32 bits, matching the SRAM port.

- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  execute stage presents a request
- in_ready  out  1  block can accept; high only in IDLE
- in_addr  in  32  byte address
- in_wdata  in  32  store data, right-justified
- in_funct3  in  3  RISC-V width/sign code: 000 b, 001 h, 010 w, 100 bu, 101 hu
- in_is_load  in  1  request is a load
- in_is_store  in  1  request is a store; never both with in_is_load
- mem_raddr  out  32  word-aligned read address {addr[31:2],2'b00}
- mem_waddr  out  32  word-aligned write address, same form
- mem_wmask  out  8  byte enables; [3:0] lanes, [7:4] always 0
- mem_r_en  out  1  read strobe
- mem_w_en  out  1  write strobe, exactly one cycle per store
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  SRAM data, registered one cycle after mem_r_en
- out_valid  out  1  result available to write-back
- out_ready  in  1  write-back accepts
- out_data  out  32  extended load data; 0 for stores, non-memory requests and errors
- out_err  out  1  misaligned or illegal funct3; no memory access was made

## Operation
- FSM, one-hot: IDLE, READ, RWAIT, WRITE, DONE.
- Latch addr, wdata, funct3, load/store flags on accept (in_valid & in_ready).
- IDLE:
  - accept with error -> DONE, out_err=1.
  - accept load -> READ.
  - accept store -> WRITE.
  - accept with neither flag -> DONE, out_data=0.
- Error cases:
  - illegal funct3 for loads: 011, 110, 111.
  - illegal funct3 for stores: any value with bit2 set, or 011.
  - misaligned: h with addr[0]=1; w with addr[1:0]!=0.
- READ: mem_r_en=1 for this cycle only -> RWAIT.
- RWAIT: mem_rdata valid.
  - Shift right by 8*addr[1:0], then extend: b/h sign-extend, bu/hu zero-extend, w as-is.
  - Register into out_data -> DONE.
- WRITE: mem_w_en=1 for this cycle only.
  - Mask: b = 4'b0001<<off; h = 4'b0011<<off; w = 4'b1111.
  - Data: b = {4{wdata[7:0]}}; h = {2{wdata[15:0]}}; w = wdata.
  - Next state DONE.
- DONE: out_valid=1; out_data/out_err held stable until out_ready. On handshake -> IDLE.
- mem_r_en and mem_w_en are taken directly from state flops, never from combinational decode. This is glitch-free, which matters because the SRAM write fires on any level-high w_en evaluation.
- mem_raddr, mem_waddr, mem_wmask, mem_wdata are driven from latched registers and stay stable across the strobe cycle. Outside strobe cycles they may hold stale values; mem_wmask=0 except in WRITE.

## Timing
- Reset: state IDLE; in_ready=1; all other outputs 0. Reset acts immediately mid-operation and cancels any pending strobe; no write occurs after rst rises.
- Load, accept at edge 0: READ in cycle 1, RWAIT in cycle 2, out_valid high from cycle 3.
- Store or error/non-memory, accept at edge 0:
  - store: WRITE in cycle 1, out_valid from cycle 2.
  - error/non-memory: out_valid from cycle 1.
- Minimum throughput: one load per 4 cycles, one store per 3 cycles, with out_ready held high.
- Back-to-back: in_ready is 0 in every non-IDLE state. A new accept is possible the cycle after the DONE handshake.
- out_valid is never withdrawn without out_ready.

## Test plan
- Signed and unsigned byte loads:
  - SRAM word at 0x80000000 = 0x80FF1234.
  - lb @0x80000003 -> mem_raddr 0x80000000, r_en one cycle, out_data 0xFFFFFF80, out_valid at cycle 3.
  - lbu same address -> 0x00000080.
- Halfword store: sh wdata 0x0000ABCD @0x80000002 -> single w_en pulse, waddr 0x80000000, wmask 0x0C, wdata 0xABCDABCD, out_data 0.
- Misaligned word load: lw @0x80000002 -> no r_en/w_en ever, out_err=1, out_valid at cycle 1.
- Back-pressure: lhu @0x80000002 of 0x8765CAFE with out_ready low for 5 cycles -> out_data 0x00008765 stable, in_ready 0 throughout, IDLE one cycle after ready.
- Reset mid-operation:
  - rst raised in RWAIT -> outputs 0, in_ready 1.
  - rst raised during a sw in WRITE -> w_en falls immediately, no second write.
  - following sw 0x11223344 @0x80000004 -> wmask 0x0F, correct completion.
- Illegal funct3: store with funct3=100 -> out_err=1, no w_en.
